// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Holds the frame FSM states, the scancode prefix bytes and the parity helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_rx_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    // A PS/2 frame uses odd parity: the 8 data bits plus the parity bit hold an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the asynchronous PS/2 lines: a two-stage synchroniser on both,
// plus a glitch filter and falling-edge strobe on the clock line only.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fe
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0] line_raw;
    logic [1:0] line_sync;

    assign line_raw = {ps2_data, ps2_clk};

    // Both lines idle high, so the synchroniser resets to 1 to avoid a spurious edge.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic sync1_reg;
            logic sync2_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                end else begin
                    sync1_reg <= line_raw[gi];
                    sync2_reg <= sync1_reg;
                end
            end

            assign line_sync[gi] = sync2_reg;
        end
    endgenerate

    logic [CW-1:0] cnt_reg, cnt_next;
    logic          filt_reg, filt_next;
    logic          fe_reg;

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        cnt_next  = '0;
        filt_next = filt_reg;
        if (line_sync[0] != filt_reg) begin
            if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                filt_next = line_sync[0];
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            filt_reg <= 1'b1;
            fe_reg   <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            filt_reg <= filt_next;
            fe_reg   <= filt_reg & ~filt_next;
        end
    end

    assign data_sync = line_sync[1];
    assign fe        = fe_reg;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: deframes device->host frames and folds E0/F0 prefixes
// into a single key event (code, extended, break) per scancode.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic data_sync;
    logic fe;

    ps2_line_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_line_filter (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .data_sync(data_sync),
        .fe       (fe)
    );

    ps2_rx_state_t  state_reg, state_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [7:0]     shift_reg, shift_next;
    logic           par_ok_reg, par_ok_next;
    logic [TW-1:0]  tmo_cnt_reg, tmo_cnt_next;
    logic           byte_stb;
    logic           frame_bad;
    logic           tmo_hit;
    logic           err_pulse;

    logic           ext_reg, brk_reg;
    logic           key_valid_reg;
    logic [7:0]     key_code_reg;
    logic           key_ext_reg, key_brk_reg;
    logic           frame_err_reg;

    // frame_err is registered, so the hit is flagged one cycle early to land
    // exactly TIMEOUT_CYC cycles after the last falling edge.
    assign tmo_hit   = (state_reg != IDLE) && !fe && (tmo_cnt_reg == TW'(TIMEOUT_CYC - 2));
    assign err_pulse = frame_bad | tmo_hit;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_ok_next  = par_ok_reg;
        byte_stb     = 1'b0;
        frame_bad    = 1'b0;

        if (state_reg == IDLE || fe || tmo_hit) begin
            tmo_cnt_next = '0;
        end else begin
            tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (fe && !data_sync) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end
            end
            DATA: begin
                if (fe) begin
                    shift_next   = {data_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fe) begin
                    par_ok_next = odd_parity_ok(shift_reg, data_sync);
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fe) begin
                    if (data_sync && par_ok_reg) begin
                        byte_stb = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (tmo_hit) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'h00;
            par_ok_reg  <= 1'b0;
            tmo_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_ok_reg  <= par_ok_next;
            tmo_cnt_reg <= tmo_cnt_next;
        end
    end

    // Prefix bytes only arm flags; the next plain byte consumes them into one event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_reg       <= 1'b0;
            brk_reg       <= 1'b0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 8'h00;
            key_ext_reg   <= 1'b0;
            key_brk_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            key_valid_reg <= 1'b0;
            frame_err_reg <= err_pulse;
            if (err_pulse) begin
                ext_reg <= 1'b0;
                brk_reg <= 1'b0;
            end else if (byte_stb) begin
                if (shift_reg == PS2_PREFIX_EXT) begin
                    ext_reg <= 1'b1;
                end else if (shift_reg == PS2_PREFIX_BRK) begin
                    brk_reg <= 1'b1;
                end else begin
                    key_valid_reg <= 1'b1;
                    key_code_reg  <= shift_reg;
                    key_ext_reg   <= ext_reg;
                    key_brk_reg   <= brk_reg;
                    ext_reg       <= 1'b0;
                    brk_reg       <= 1'b0;
                end
            end
        end
    end

    assign key_valid = key_valid_reg;
    assign key_code  = key_code_reg;
    assign key_ext   = key_ext_reg;
    assign key_brk   = key_brk_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: a PS/2 device model drives frames and a
// scancode-level model of prefix handling predicts events, errors and timing.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 300;
    localparam int HALF_BIT    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       frame_err;

    ps2_kbd_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ext  (key_ext),
        .key_brk  (key_brk),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observed event log, filled on the falling clock edge.
    int         kv_cnt = 0;
    int         err_cnt = 0;
    int         kv_cyc = 0;
    int         err_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                kv_cnt++;
                kv_cyc = cyc;
            end
            if (frame_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (key_valid || frame_err)
                check("valid_err_excl", {31'd0, key_valid && frame_err}, 32'd0);
        end
    end

    // Reference model state: pending prefixes and the last reported event.
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_kext = 1'b0;
    logic       m_kbrk = 1'b0;
    int         last_fall_cyc = 0;
    int         stop_fall_cyc = 0;
    int         ref_lat = -1;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good, output int exp_kv, output int exp_err);
        exp_kv  = 0;
        exp_err = 0;
        if (!good) begin
            exp_err = 1;
            m_ext   = 1'b0;
            m_brk   = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_kv = 1;
            m_code = b;
            m_kext = m_ext;
            m_kbrk = m_brk;
            m_ext  = 1'b0;
            m_brk  = 1'b0;
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        check("rst_key_valid", {31'd0, key_valid}, 32'd0);
        check("rst_key_code", {24'd0, key_code}, 32'd0);
        check("rst_key_ext", {31'd0, key_ext}, 32'd0);
        check("rst_key_brk", {31'd0, key_brk}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        m_ext = 1'b0; m_brk = 1'b0; m_code = 8'h00; m_kext = 1'b0; m_kbrk = 1'b0;
        kv_cnt = 0;
        err_cnt = 0;
        $display("reset pulse at cycle %0d", cyc);
    endtask

    // Drives the first nbits bits of a frame; rst_at >= 0 pulses reset after that bit.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int rst_at);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(HALF_BIT / 2);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cyc(HALF_BIT);
            ps2_clk = 1'b1;
            wait_cyc(HALF_BIT / 2);
            if (i == rst_at) pulse_rst();
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int ekv, eerr, lat;
        kv_cnt  = 0;
        err_cnt = 0;
        send_frame(b, bad_par, bad_stop, 11, -1);
        wait_cyc(10);
        model_frame(b, !bad_par && !bad_stop, ekv, eerr);
        check("kv_cnt", kv_cnt, ekv);
        check("err_cnt", err_cnt, eerr);
        check("key_code", {24'd0, key_code}, {24'd0, m_code});
        check("key_ext", {31'd0, key_ext}, {31'd0, m_kext});
        check("key_brk", {31'd0, key_brk}, {31'd0, m_kbrk});
        if (ekv == 1 && kv_cnt == 1) begin
            lat = kv_cyc - stop_fall_cyc;
            if (ref_lat < 0) begin
                ref_lat = lat;
                check("lat_range", {31'd0, (lat >= FILTER_LEN + 2) && (lat <= FILTER_LEN + 4)}, 32'd1);
            end else begin
                check("lat", lat, ref_lat);
            end
        end
        $display("frame %02h par_bad=%0b stop_bad=%0b -> kv=%0d err=%0d code=%02h ext=%0b brk=%0b",
                 b, bad_par, bad_stop, kv_cnt, err_cnt, key_code, key_ext, key_brk);
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] rb;

        rst = 1'b1;
        wait_cyc(5);
        check("reset_key_valid", {31'd0, key_valid}, 32'd0);
        check("reset_key_code", {24'd0, key_code}, 32'd0);
        check("reset_key_ext", {31'd0, key_ext}, 32'd0);
        check("reset_key_brk", {31'd0, key_brk}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        wait_cyc(20);

        do_frame(8'h1C, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h1C, 0, 0);
        do_frame(8'hE0, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h75, 0, 0);
        do_frame(8'hE0, 0, 0);
        do_frame(8'hE0, 0, 0);
        do_frame(8'h6B, 0, 0);

        do_frame(8'h1C, 1, 0);
        do_frame(8'h29, 0, 0);
        do_frame(8'hF0, 0, 0);
        do_frame(8'h1C, 0, 1);
        do_frame(8'h33, 0, 0);

        // Short low glitch on the idle clock while data is low must not look like a start bit.
        kv_cnt = 0; err_cnt = 0;
        ps2_data = 1'b0;
        wait_cyc(2);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(2);
        ps2_data = 1'b1;
        wait_cyc(TIMEOUT_CYC + 50);
        check("glitch_kv", kv_cnt, 0);
        check("glitch_err", err_cnt, 0);
        $display("glitch 3 cycles -> kv=%0d err=%0d", kv_cnt, err_cnt);
        do_frame(8'h4D, 0, 0);

        // Abandoned frame after 4 data bits: timeout error at a fixed distance from the last edge.
        do_frame(8'hE0, 0, 0);
        kv_cnt = 0; err_cnt = 0;
        send_frame(8'h5A, 0, 0, 5, -1);
        wait_cyc(TIMEOUT_CYC + 50);
        check("tmo_err_cnt", err_cnt, 1);
        check("tmo_kv_cnt", kv_cnt, 0);
        check("tmo_err_cyc", err_cyc, last_fall_cyc + ref_lat - 1 + TIMEOUT_CYC);
        m_ext = 1'b0; m_brk = 1'b0;
        $display("timeout frame -> err=%0d at +%0d cycles", err_cnt, err_cyc - last_fall_cyc);
        do_frame(8'h5A, 0, 0);

        // Reset while idle drops a pending prefix.
        do_frame(8'hE0, 0, 0);
        pulse_rst();
        wait_cyc(20);
        do_frame(8'h1C, 0, 0);

        // Reset in the middle of a frame: leftovers end in at most one error.
        do_frame(8'hE0, 0, 0);
        do_frame(8'h72, 0, 0);
        do_frame(8'hE0, 0, 0);
        send_frame(8'hE0, 0, 0, 11, 3);
        wait_cyc(TIMEOUT_CYC + 50);
        check("midrst_err_le1", {31'd0, err_cnt <= 1}, 32'd1);
        check("midrst_kv", kv_cnt, 0);
        $display("mid-frame reset -> kv=%0d err=%0d", kv_cnt, err_cnt);
        m_ext = 1'b0; m_brk = 1'b0;
        do_frame(8'h1C, 0, 0);

        for (int i = 0; i < 30; i++) begin
            r  = $urandom_range(0, 9);
            rb = 8'($urandom_range(0, 255));
            case (r)
                0, 1: do_frame(8'hE0, 0, 0);
                2:    do_frame(8'hF0, 0, 0);
                3:    do_frame(rb, 1, 0);
                4:    do_frame(rb, 0, 1);
                default: do_frame(rb, 0, 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
